// File: rtl/hazard_unit_pipe.sv
// Hazard unit for the F/D/E/M/W pipeline: tracks E/M/W destination tags and
// produces operand forwarding selects, load-use stalls, flushes and event counts.

module hazard_fwd_lane #(
  parameter int AW    = 4,
  parameter int PCREG = 15
) (
  input  logic [AW-1:0] rae,
  input  logic          used_e,
  input  logic [AW-1:0] wa3m,
  input  logic          rw_m,
  input  logic [AW-1:0] wa3w,
  input  logic          rw_w,
  input  logic [AW-1:0] rad,
  input  logic          used_d,
  input  logic [AW-1:0] wa3e,
  output logic [1:0]    fwd,
  output logic          ld_hit
);
  localparam logic [AW-1:0] PC = AW'(PCREG);

  logic match_m, match_w;

  assign match_m = used_e & rw_m & (rae == wa3m) & (rae != PC);
  assign match_w = used_e & rw_w & (rae == wa3w) & (rae != PC);
  // M holds the younger result, so it wins over W
  assign fwd     = match_m ? 2'b10 : (match_w ? 2'b01 : 2'b00);
  assign ld_hit  = used_d & (rad == wa3e) & (rad != PC);
endmodule

module hazard_unit_pipe #(
  parameter int AW    = 4,
  parameter int NSRC  = 2,
  parameter int PCREG = 15,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC*AW-1:0] RAD,
  input  logic [NSRC-1:0]    SrcUsedD,
  input  logic [AW-1:0]      WA3D,
  input  logic               RegWriteD,
  input  logic               MemtoRegD,
  input  logic               PCSrcD,
  input  logic               BranchD,
  input  logic               CondExE,
  input  logic               CntClr,
  output logic [2*NSRC-1:0]  ForwardE,
  output logic               StallF,
  output logic               StallD,
  output logic               FlushD,
  output logic               FlushE,
  output logic               BranchTakenE,
  output logic [CNTW-1:0]    StallCnt,
  output logic [CNTW-1:0]    FlushCnt
);
  typedef struct packed {
    logic [NSRC-1:0][AW-1:0] ra;
    logic [NSRC-1:0]         used;
    logic [AW-1:0]           wa3;
    logic                    rw;
    logic                    m2r;
    logic                    pcs;
    logic                    br;
  } e_stage_t;

  typedef struct packed {
    logic [AW-1:0] wa3;
    logic          rw;
    logic          pcs;
  } mw_stage_t;

  e_stage_t  e_q, e_d;
  mw_stage_t m_q, w_q;
  logic [NSRC-1:0] ld_hit;
  logic ldr_stall, pc_wr_pending;

  genvar i;
  generate
    for (i = 0; i < NSRC; i++) begin : g_lane
      hazard_fwd_lane #(.AW(AW), .PCREG(PCREG)) u_lane (
        .rae    (e_q.ra[i]),
        .used_e (e_q.used[i]),
        .wa3m   (m_q.wa3),
        .rw_m   (m_q.rw),
        .wa3w   (w_q.wa3),
        .rw_w   (w_q.rw),
        .rad    (RAD[i*AW +: AW]),
        .used_d (SrcUsedD[i]),
        .wa3e   (e_q.wa3),
        .fwd    (ForwardE[2*i +: 2]),
        .ld_hit (ld_hit[i])
      );
    end
  endgenerate

  // Conservative: a predicated-off load still stalls its consumer
  assign ldr_stall     = e_q.m2r & e_q.rw & (|ld_hit);
  assign pc_wr_pending = PCSrcD | e_q.pcs | m_q.pcs;
  assign BranchTakenE  = e_q.br & CondExE;

  assign StallF = ldr_stall | pc_wr_pending;
  assign StallD = ldr_stall;
  assign FlushE = ldr_stall | BranchTakenE;
  assign FlushD = pc_wr_pending | w_q.pcs | BranchTakenE;

  always_comb begin
    e_d = '0;
    if (!FlushE) begin
      for (int k = 0; k < NSRC; k++) e_d.ra[k] = RAD[k*AW +: AW];
      e_d.used = SrcUsedD;
      e_d.wa3  = WA3D;
      e_d.rw   = RegWriteD;
      e_d.m2r  = MemtoRegD;
      e_d.pcs  = PCSrcD;
      e_d.br   = BranchD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      e_q     <= e_d;
      m_q.wa3 <= e_q.wa3;
      m_q.rw  <= e_q.rw & CondExE;
      m_q.pcs <= e_q.pcs & CondExE;
      w_q     <= m_q;
      if (CntClr)                          StallCnt <= '0;
      else if (ldr_stall && StallCnt != '1) StallCnt <= StallCnt + 1'b1;
      if (CntClr)                             FlushCnt <= '0;
      else if (BranchTakenE && FlushCnt != '1) FlushCnt <= FlushCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit_pipe.sv
// Scoreboard bench for hazard_unit_pipe: directed hazard scenarios plus random
// traffic, each cycle checked against an instruction-level pipeline model.

module tb_hazard_unit_pipe;
  localparam int AW = 4, NSRC = 2, PCREG = 15, CNTW = 3;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [NSRC*AW-1:0] RAD;
  logic [NSRC-1:0] SrcUsedD;
  logic [AW-1:0] WA3D;
  logic RegWriteD, MemtoRegD, PCSrcD, BranchD, CondExE, CntClr;
  logic [2*NSRC-1:0] ForwardE;
  logic StallF, StallD, FlushD, FlushE, BranchTakenE;
  logic [CNTW-1:0] StallCnt, FlushCnt;

  hazard_unit_pipe #(.AW(AW), .NSRC(NSRC), .PCREG(PCREG), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .RAD(RAD), .SrcUsedD(SrcUsedD), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
    .CondExE(CondExE), .CntClr(CntClr), .ForwardE(ForwardE), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .BranchTakenE(BranchTakenE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ra0, ra1, sud, wa;
    bit rw, m2r, pcs, br, cond, clr, rst, skip;
  } stim_t;

  // One in-flight instruction as the model sees it
  typedef struct {
    int ra[2];
    bit used[2];
    int wa;
    bit rw, m2r, pcs, br;
  } instr_t;

  typedef struct {
    int fwd;
    bit sf, sd, fd, fe, bt;
    int sc, fc;
  } exp_t;

  exp_t   sbq[$];
  instr_t ie, im, iw;
  int     scnt = 0, fcnt = 0;
  int     n_chk = 0, n_fail = 0;

  function automatic instr_t bubble();
    instr_t b;
    b.ra = '{0, 0}; b.used = '{0, 0}; b.wa = 0;
    b.rw = 0; b.m2r = 0; b.pcs = 0; b.br = 0;
    return b;
  endfunction

  function automatic stim_t mk(int ra0, int ra1, int sud, int wa, bit rw, bit m2r,
                               bit pcs, bit br, bit cond, bit clr, bit rst);
    stim_t s;
    s.ra0 = ra0; s.ra1 = ra1; s.sud = sud; s.wa = wa; s.rw = rw; s.m2r = m2r;
    s.pcs = pcs; s.br = br; s.cond = cond; s.clr = clr; s.rst = rst; s.skip = 0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit ld, pend;
    int ra[2];
    @(negedge clk);
    reset = s.rst; CntClr = s.clr; CondExE = s.cond;
    RAD = {AW'(s.ra1), AW'(s.ra0)}; SrcUsedD = NSRC'(s.sud); WA3D = AW'(s.wa);
    RegWriteD = s.rw; MemtoRegD = s.m2r; PCSrcD = s.pcs; BranchD = s.br;
    ra = '{s.ra0, s.ra1};
    e.fwd = 0;
    for (int i = 0; i < NSRC; i++) begin
      int sel = 0;
      if (ie.used[i] && ie.ra[i] != PCREG) begin
        if (im.rw && im.wa == ie.ra[i]) sel = 2;
        else if (iw.rw && iw.wa == ie.ra[i]) sel = 1;
      end
      e.fwd |= sel << (2 * i);
    end
    ld = 0;
    for (int i = 0; i < NSRC; i++)
      if (s.sud[i] && ra[i] == ie.wa && ra[i] != PCREG) ld = 1;
    ld   = ld && ie.m2r && ie.rw;
    pend = s.pcs || ie.pcs || im.pcs;
    e.bt = ie.br && s.cond;
    e.sf = ld || pend;
    e.sd = ld;
    e.fe = ld || e.bt;
    e.fd = pend || iw.pcs || e.bt;
    e.sc = scnt;
    e.fc = fcnt;
    if (!s.skip) sbq.push_back(e);
    if (s.rst) begin
      ie = bubble(); im = bubble(); iw = bubble(); scnt = 0; fcnt = 0;
    end else begin
      iw = im;
      im = ie;
      im.rw  = ie.rw && s.cond;
      im.pcs = ie.pcs && s.cond;
      if (e.fe) ie = bubble();
      else begin
        ie.ra = ra; ie.used = '{s.sud[0], s.sud[1]}; ie.wa = s.wa;
        ie.rw = s.rw; ie.m2r = s.m2r; ie.pcs = s.pcs; ie.br = s.br;
      end
      if (s.clr) scnt = 0; else if (ld && scnt < CMAX) scnt++;
      if (s.clr) fcnt = 0; else if (e.bt && fcnt < CMAX) fcnt++;
    end
  endtask

  task automatic op(int ra0, int ra1, int sud, int wa, bit rw, bit m2r, bit pcs, bit br, bit cond);
    drive(mk(ra0, ra1, sud, wa, rw, m2r, pcs, br, cond, 0, 0));
  endtask

  task automatic nop(int n);
    repeat (n) op(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk(string nm, logic [31:0] act, int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ForwardE", 32'(ForwardE), e.fwd);
      chk("StallF", 32'(StallF), int'(e.sf));
      chk("StallD", 32'(StallD), int'(e.sd));
      chk("FlushD", 32'(FlushD), int'(e.fd));
      chk("FlushE", 32'(FlushE), int'(e.fe));
      chk("BranchTakenE", 32'(BranchTakenE), int'(e.bt));
      chk("StallCnt", 32'(StallCnt), e.sc);
      chk("FlushCnt", 32'(FlushCnt), e.fc);
    end
  end

  function automatic int rr();
    case ($urandom_range(0, 4))
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 15;
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    stim_t s;
    ie = bubble(); im = bubble(); iw = bubble();
    s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); s.skip = 1; drive(s);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    nop(2);
    // back-to-back RAW, then RAW with one instruction between
    op(0, 0, 0, 1, 1, 0, 0, 0, 1);
    op(1, 0, 1, 0, 0, 0, 0, 0, 1);
    nop(2);
    op(0, 0, 0, 1, 1, 0, 0, 0, 1);
    nop(1);
    op(1, 0, 1, 0, 0, 0, 0, 0, 1);
    nop(3);
    // M/W priority and PC exclusion
    op(0, 0, 0, 2, 1, 0, 0, 0, 1);
    op(0, 0, 0, 2, 1, 0, 0, 0, 1);
    op(2, 15, 3, 0, 0, 0, 0, 0, 1);
    nop(1);
    op(0, 0, 0, 15, 1, 0, 0, 0, 1);
    op(2, 15, 3, 0, 0, 0, 0, 0, 1);
    nop(3);
    // load-use: consumer re-presented in D while stalled
    op(0, 0, 0, 3, 1, 1, 0, 0, 1);
    op(3, 0, 1, 0, 0, 0, 0, 0, 1);
    op(3, 0, 1, 0, 0, 0, 0, 0, 1);
    nop(3);
    // branch taken, then branch with failed condition that also writes R4
    op(0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(2);
    op(0, 0, 0, 4, 1, 0, 0, 1, 1);
    op(4, 4, 3, 0, 0, 0, 0, 0, 0);
    op(4, 4, 3, 0, 0, 0, 0, 0, 1);
    nop(3);
    // PC write
    op(0, 0, 0, 15, 1, 0, 1, 0, 1);
    nop(5);
    // nine load-use events to saturate the 3-bit counter
    repeat (9) begin
      op(0, 0, 0, 3, 1, 1, 0, 0, 1);
      op(3, 0, 1, 0, 0, 0, 0, 0, 1);
    end
    nop(1);
    op(0, 0, 0, 3, 1, 1, 0, 0, 1);
    drive(mk(3, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    nop(1);
    // reset with a load-use hazard in flight
    op(0, 0, 0, 3, 1, 1, 0, 0, 1);
    drive(mk(3, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1));
    nop(2);
    repeat (600)
      drive(mk(rr(), rr(), int'($urandom_range(0, 3)), rr(), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0)));
    repeat (3) @(negedge clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
